// File: rtl/mem_pkg.sv
// Shared constants for the two-port memory arbiter: command codes,
// sequencer states and requester port indices.
package mem_pkg;
   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam int CPU = 0;
   localparam int LD  = 1;

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

   // 2'b11 is reserved and behaves as MNONE
   function automatic logic is_req(input logic [1:0] cmd);
      return (cmd == MREAD) || (cmd == MWRITE);
   endfunction
endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to the
// port that did not own the previous access.
module rr_pick (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] pick
);
   always_comb begin
      pick = req;
      if (req == 2'b11) pick = last_grant ? 2'b01 : 2'b10;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read RAM between the CPU and loader ports using a
// fixed IDLE/ACCESS/CAPTURE/DONE sequence with round-robin arbitration.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int RAM_AW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        cpu_cmd,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   input  logic [1:0]        ld_cmd,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              ld_done,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [1:0]        grant,
   output logic              busy
);
   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              own_q, own_d;
   logic [1:0]        cmd_q, cmd_d;
   logic              io_q, io_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
   logic              cpu_done_q, cpu_done_d;
   logic              ld_done_q, ld_done_d;
   logic [1:0]        grant_q, grant_d;
   logic              busy_q, busy_d;
   logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
   logic              ram_write_q, ram_write_d;
   logic [DATA_W-1:0] ram_din_q, ram_din_d;

   logic [1:0]        req, pick;
   logic [1:0]        sel_cmd;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [DATA_W-1:0] rd_val;

   assign req = {is_req(ld_cmd), is_req(cpu_cmd)};

   rr_pick u_pick (
      .req       (req),
      .last_grant(last_q),
      .pick      (pick)
   );

   always_comb begin
      sel_cmd   = pick[LD] ? ld_cmd   : cpu_cmd;
      sel_addr  = pick[LD] ? ld_addr  : cpu_addr;
      sel_wdata = pick[LD] ? ld_wdata : cpu_wdata;
      rd_val    = io_q ? '0 : ram_dout;
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      own_d       = own_q;
      cmd_d       = cmd_q;
      io_d        = io_q;
      cpu_rdata_d = cpu_rdata_q;
      ld_rdata_d  = ld_rdata_q;
      cpu_done_d  = 1'b0;
      ld_done_d   = 1'b0;
      grant_d     = grant_q;
      ram_addr_d  = ram_addr_q;
      ram_write_d = 1'b0;
      ram_din_d   = ram_din_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               own_d      = pick[LD];
               cmd_d      = sel_cmd;
               io_d       = sel_addr[ADDR_W-1];
               grant_d    = pick;
               ram_addr_d = sel_addr[RAM_AW-1:0];
               // the write strobe is registered so it is high for the ACCESS cycle only
               if (sel_cmd == MWRITE) begin
                  ram_din_d   = sel_wdata;
                  ram_write_d = !sel_addr[ADDR_W-1];
               end
               state_d = ACCESS;
            end
         end
         ACCESS: state_d = CAPTURE;
         CAPTURE: begin
            if (cmd_q == MREAD) begin
               if (own_q) ld_rdata_d  = rd_val;
               else       cpu_rdata_d = rd_val;
            end
            if (own_q) ld_done_d  = 1'b1;
            else       cpu_done_d = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            last_d  = own_q;
            grant_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         own_q       <= 1'b0;
         cmd_q       <= MNONE;
         io_q        <= 1'b0;
         cpu_rdata_q <= '0;
         ld_rdata_q  <= '0;
         cpu_done_q  <= 1'b0;
         ld_done_q   <= 1'b0;
         grant_q     <= '0;
         busy_q      <= 1'b0;
         ram_addr_q  <= '0;
         ram_write_q <= 1'b0;
         ram_din_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         own_q       <= own_d;
         cmd_q       <= cmd_d;
         io_q        <= io_d;
         cpu_rdata_q <= cpu_rdata_d;
         ld_rdata_q  <= ld_rdata_d;
         cpu_done_q  <= cpu_done_d;
         ld_done_q   <= ld_done_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         ram_addr_q  <= ram_addr_d;
         ram_write_q <= ram_write_d;
         ram_din_q   <= ram_din_d;
      end
   end

   assign cpu_rdata = cpu_rdata_q;
   assign ld_rdata  = ld_rdata_q;
   assign cpu_done  = cpu_done_q;
   assign ld_done   = ld_done_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign ram_addr  = ram_addr_q;
   assign ram_write = ram_write_q;
   assign ram_din   = ram_din_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter and access sequencer that shares the single 256x16 synchronous-read RAM between the CPU memory port and a second requester, the program loader/debug port. It sits between the CPU, the loader and the RAM. Each access runs through a fixed four-state sequence, and contention is resolved round-robin so that neither port starves. It replaces direct CPU-to-RAM wiring, so the loader can fill or inspect memory while the CPU runs.

## Interface
Parameters:
- ADDR_W, 9, requester address width; bit ADDR_W-1 set selects the IO space, which is not backed by RAM.
- DATA_W, 16, data width.
- RAM_AW, 8, RAM address width; the low bits of the address are used.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- cpu_cmd  in  2  CPU command.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data, held register.
- cpu_done  out  1  one-cycle completion pulse.
- ld_cmd, ld_addr, ld_wdata, ld_rdata, ld_done  loader port; same widths and meanings as the CPU port.
- ram_addr  out  RAM_AW  RAM address.
- ram_write  out  1  RAM write enable.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data, valid one cycle after the address.
- grant  out  2  one-hot current owner: bit0 is the CPU, bit1 is the loader. The value is 0 in IDLE.
- busy  out  1  asserted whenever the state is not IDLE.

## Operation
- Command encoding: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10. The value 2'b11 is treated as MNONE.
- State machine states are IDLE, ACCESS, CAPTURE and DONE.
  - IDLE: if at least one port presents a read or write, the winner is picked and its cmd/addr/wdata are latched. At the next edge the state moves to ACCESS. Otherwise the state stays in IDLE.
  - ACCESS: ram_addr is driven with latched_addr[RAM_AW-1:0]. For a write, ram_din is driven with the latched data and ram_write=1 for this cycle only. The next state is CAPTURE.
  - CAPTURE: for a read, the owner's rdata register loads ram_dout at the end of this cycle. The next state is DONE.
  - DONE: the owner's done is 1 for exactly this cycle. last_grant is updated to the owner. The next state is IDLE.
- Arbitration:
  - If only one port requests, that port wins.
  - If both ports request, the port that is not last_grant wins.
  - last_grant resets to "loader", so the CPU wins the first tie.
- IO-space access (addr[ADDR_W-1]=1): ram_write is never asserted. A read captures 16'h0000. The access still completes with the normal done timing.
- A port's rdata register changes only on that port's own reads. Writes and the other port's accesses leave it unchanged.
- Inputs are latched in IDLE, so a requester may change its addr/wdata after that edge. A requester must present its next command, or MNONE, in the cycle after its done. A command still held in IDLE is treated as a new request.
- Reset values:
  - state=IDLE, last_grant=loader.
  - All outputs are 0: rdata registers, done, grant, busy, ram_addr, ram_write and ram_din.
- Reset asserted mid-access: the state goes to IDLE immediately and ram_write drops asynchronously. The in-flight access is dropped and no done is issued. A write is lost only if reset arrives before the ACCESS edge.

## Timing
- A request seen in IDLE cycle t has ram_write/ram_addr in cycle t+1, read data captured at the end of t+2, and done high in t+3.
- Fixed latency is 3 cycles from the arbitration edge. Peak throughput is one access per 4 cycles.
- With both ports requesting continuously, grants alternate CPU, loader, CPU, and so on. The worst-case wait for a port is 4 cycles.
- grant is valid from the ACCESS cycle through the DONE cycle.

## Structure
- Package mem_pkg holds the MNONE/MREAD/MWRITE constants, the state encoding (IDLE, ACCESS, CAPTURE, DONE), and the port indices CPU=0, LD=1.
- Sub-module rr_pick: the combinational two-way round-robin chooser. Inputs are req[1:0] and last_grant; output is a one-hot pick.
- Everything else lives in mem_arbiter: the state register, the latches and the rdata registers.

## Test plan
- Reset then idle: all outputs are 0 and busy=0. Release reset with both cmds MNONE; the block stays in IDLE for 10 cycles.
- CPU write then read: CPU MWRITE addr 9'h005, data 16'hABCD, gives ram_write=1 for one cycle with ram_addr=8'h05. A following MREAD of 9'h005 gives cpu_rdata=16'hABCD with cpu_done exactly 3 cycles after the request edge. ld_rdata is unchanged.
- Simultaneous requests: both ports request from reset. The CPU is served first, then the loader; grant goes 01, then 10. With both requests held continuously, the grants strictly alternate over 8 accesses.
- IO access: loader MWRITE to 9'h100 gives no ram_write. Loader MREAD of 9'h100 gives ld_rdata=16'h0000 and ld_done on schedule.
- Reset mid-access: assert reset in the CAPTURE cycle of a CPU read. The block returns to IDLE, no cpu_done is issued, and cpu_rdata=0. After release, a new read completes normally.
- Loader load, then CPU fetch: the loader writes 16'hD005 to 9'h000. A subsequent CPU MREAD of 9'h000 returns 16'hD005.
